// File: rtl/smul_rr_arbiter.sv
// smul_rr_arbiter: round-robin sharing of one registered 8x8 signed multiplier among N_REQ requesters.
// Define SMUL_OUTREG_EN to add a register after the multiplier (latency 3 instead of 2).
module signed_multiplier (
    input  logic signed [7:0]  a,
    input  logic signed [7:0]  b,
    output logic signed [15:0] z
);
    assign z = a * b;
endmodule

module smul_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_a,
    input  logic [8*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]   req_ready,
    output logic               rsp_valid,
    output logic [ID_W-1:0]    rsp_id,
    output logic [15:0]        rsp_z,
    output logic               busy,
    output logic [15:0]        op_cnt
);
    logic [N_REQ-1:0] hi, cand, gnt;
    logic [ID_W-1:0]  win;
    logic [7:0]       a_sel, b_sel;
    logic [15:0]      z;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic             s1_v_q, s1_v_d;
    logic [7:0]       s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [ID_W-1:0]  s1_id_q, s1_id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [15:0]      rsp_z_q, rsp_z_d;
    logic [15:0]      op_cnt_q, op_cnt_d;
`ifdef SMUL_OUTREG_EN
    logic             s2_v_q, s2_v_d;
    logic [ID_W-1:0]  s2_id_q, s2_id_d;
    logic [15:0]      s2_z_q, s2_z_d;
`endif

    // Requests above the pointer win first; otherwise wrap to the lowest asserted index.
    always_comb begin
        hi = req_valid & ~((N_REQ'(2) << rr_ptr_q) - N_REQ'(1));
        cand = (|hi) ? hi : req_valid;
        gnt = cand & (~cand + N_REQ'(1));
        win = '0;
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N_REQ; i++)
            if (gnt[i]) begin
                win = ID_W'(i);
                a_sel = req_a[8*i +: 8];
                b_sel = req_b[8*i +: 8];
            end
    end

    assign req_ready = rst ? '0 : gnt;

    signed_multiplier u_mul (
        .a(s1_a_q),
        .b(s1_b_q),
        .z(z)
    );

    always_comb begin
        rr_ptr_d = (|gnt) ? win : rr_ptr_q;
        s1_v_d = |gnt;
        s1_a_d = (|gnt) ? a_sel : s1_a_q;
        s1_b_d = (|gnt) ? b_sel : s1_b_q;
        s1_id_d = (|gnt) ? win : s1_id_q;
`ifdef SMUL_OUTREG_EN
        s2_v_d = s1_v_q;
        s2_z_d = s1_v_q ? z : s2_z_q;
        s2_id_d = s1_v_q ? s1_id_q : s2_id_q;
        rsp_valid_d = s2_v_q;
        rsp_z_d = s2_v_q ? s2_z_q : rsp_z_q;
        rsp_id_d = s2_v_q ? s2_id_q : rsp_id_q;
`else
        rsp_valid_d = s1_v_q;
        rsp_z_d = s1_v_q ? z : rsp_z_q;
        rsp_id_d = s1_v_q ? s1_id_q : rsp_id_q;
`endif
        op_cnt_d = op_cnt_q + {15'd0, rsp_valid_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= ID_W'(N_REQ - 1);
            s1_v_q <= 1'b0;
            s1_a_q <= '0;
            s1_b_q <= '0;
            s1_id_q <= '0;
`ifdef SMUL_OUTREG_EN
            s2_v_q <= 1'b0;
            s2_z_q <= '0;
            s2_id_q <= '0;
`endif
            rsp_valid_q <= 1'b0;
            rsp_z_q <= '0;
            rsp_id_q <= '0;
            op_cnt_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            s1_v_q <= s1_v_d;
            s1_a_q <= s1_a_d;
            s1_b_q <= s1_b_d;
            s1_id_q <= s1_id_d;
`ifdef SMUL_OUTREG_EN
            s2_v_q <= s2_v_d;
            s2_z_q <= s2_z_d;
            s2_id_q <= s2_id_d;
`endif
            rsp_valid_q <= rsp_valid_d;
            rsp_z_q <= rsp_z_d;
            rsp_id_q <= rsp_id_d;
            op_cnt_q <= op_cnt_d;
        end
    end

`ifdef SMUL_OUTREG_EN
    assign busy = s1_v_q | s2_v_q | rsp_valid_q;
`else
    assign busy = s1_v_q | rsp_valid_q;
`endif
    assign rsp_valid = rsp_valid_q;
    assign rsp_id = rsp_id_q;
    assign rsp_z = rsp_z_q;
    assign op_cnt = op_cnt_q;
endmodule

// File: tb/tb_smul_rr_arbiter.sv
// tb_smul_rr_arbiter: directed vector table, random traffic against a queue model, reset and wrap sequences.
module tb_smul_rr_arbiter;
    localparam int N = 4;
    localparam int IW = 3;
`ifdef SMUL_OUTREG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] req_valid = '0;
    logic [8*N-1:0] req_a = '0, req_b = '0;
    logic [N-1:0] req_ready;
    logic rsp_valid, busy;
    logic [IW-1:0] rsp_id;
    logic [15:0] rsp_z, op_cnt;
    int checks = 0, errors = 0;

    smul_rr_arbiter #(.N_REQ(N), .ID_W(IW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_z(rsp_z),
        .busy(busy), .op_cnt(op_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int due;
        int id;
        logic [15:0] z;
    } rsp_t;
    rsp_t q[$];
    int ptr, cyc, mcnt, w, lat;

    function automatic logic [15:0] prod(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = $signed(a) * $signed(b);
        return p[15:0];
    endfunction

    // One clock of model-checked traffic: arbitration by linear search, responses from a due-time queue.
    task automatic step(input logic r, input logic [N-1:0] v, input logic [8*N-1:0] a,
                        input logic [8*N-1:0] b, output int win);
        int x;
        logic [N-1:0] er;
        rsp_t e;
        @(negedge clk);
        rst = r; req_valid = v; req_a = a; req_b = b;
        #1;
        x = -1;
        er = '0;
        if (r) begin
            ptr = N - 1; q.delete(); mcnt = 0;
        end else
            for (int k = 1; k <= N; k++)
                if (x < 0 && v[(ptr + k) % N]) x = (ptr + k) % N;
        if (x >= 0) er[x] = 1'b1;
        chk("ready", req_ready, er);
        chk("busy", busy, q.size() != 0);
        chk("op_cnt", op_cnt, mcnt);
        if (q.size() != 0 && q[0].due == cyc) begin
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_id", rsp_id, q[0].id);
            chk("rsp_z", rsp_z, q[0].z);
            mcnt = (mcnt + 1) % 65536;
            void'(q.pop_front());
        end else
            chk("rsp_valid", rsp_valid, 0);
        if (x >= 0) begin
            e.due = cyc + LAT; e.id = x; e.z = prod(a[8*x +: 8], b[8*x +: 8]);
            q.push_back(e);
            ptr = x;
        end
        cyc++;
        win = x;
    endtask

    typedef struct {
        logic r;
        logic [N-1:0] v;
        logic [8*N-1:0] a, b;
        logic [N-1:0] rdy;
        logic rv;
        logic [IW-1:0] id;
        logic [15:0] z;
        int cnt;
    } vec_t;
    vec_t tv[$];
    logic s_rv[$];
    logic [IW-1:0] s_id[$];
    logic [15:0] s_z[$], s_cnt[$];
    logic [N-1:0] pend = '0;
    logic [8*N-1:0] pa = '0, pb = '0;

    task automatic add(input logic r, input logic [N-1:0] v, input logic [31:0] a, input logic [31:0] b,
                       input logic [N-1:0] rdy, input logic rv, input logic [IW-1:0] id,
                       input logic [15:0] z, input int cnt);
        vec_t t;
        t.r = r; t.v = v; t.a = a; t.b = b; t.rdy = rdy; t.rv = rv; t.id = id; t.z = z; t.cnt = cnt;
        tv.push_back(t);
    endtask

    initial begin
        // Response fields are written for latency 2; the compare loop shifts them by LAT-2 rows.
        add(0, 4'h4, 32'h00800000, 32'h00800000, 4'h4, 0, 0, 16'h0000, 0);
        add(0, 4'h0, 0, 0, 4'h0, 0, 0, 16'h0000, 0);
        add(0, 4'h0, 0, 0, 4'h0, 1, 2, 16'h4000, 0);
        add(0, 4'h0, 0, 0, 4'h0, 0, 0, 16'h0000, 1);
        add(0, 4'h0, 0, 0, 4'h0, 0, 0, 16'h0000, -1);
        add(1, 4'hF, 32'h04030201, 32'hFDFDFDFD, 4'h0, 0, 0, 16'h0000, 0);
        add(0, 4'hF, 32'h04030201, 32'hFDFDFDFD, 4'h1, 0, 0, 16'h0000, 0);
        add(0, 4'hF, 32'h04030201, 32'hFDFDFDFD, 4'h2, 0, 0, 16'h0000, 0);
        add(0, 4'hF, 32'h04030201, 32'hFDFDFDFD, 4'h4, 1, 0, 16'hFFFD, 0);
        add(0, 4'hF, 32'h04030201, 32'hFDFDFDFD, 4'h8, 1, 1, 16'hFFFA, 1);
        add(0, 4'hF, 32'h04030201, 32'hFDFDFDFD, 4'h1, 1, 2, 16'hFFF7, 2);
        add(0, 4'hF, 32'h04030201, 32'hFDFDFDFD, 4'h2, 1, 3, 16'hFFF4, 3);
        add(0, 4'hF, 32'h04030201, 32'hFDFDFDFD, 4'h4, 1, 0, 16'hFFFD, 4);
        add(0, 4'hF, 32'h04030201, 32'hFDFDFDFD, 4'h8, 1, 1, 16'hFFFA, 5);
        add(0, 4'h0, 0, 0, 4'h0, 1, 2, 16'hFFF7, 6);
        add(0, 4'h0, 0, 0, 4'h0, 1, 3, 16'hFFF4, 7);
        add(0, 4'h0, 0, 0, 4'h0, 0, 0, 16'h0000, 8);
        add(0, 4'h2, 32'h00007F00, 32'h00008000, 4'h2, 0, 0, 16'h0000, 8);
        add(0, 4'h2, 32'h00007F00, 32'h0000FF00, 4'h2, 0, 0, 16'h0000, 8);
        add(0, 4'h2, 32'h00007F00, 32'h00000000, 4'h2, 1, 1, 16'hC080, 8);
        add(0, 4'h2, 32'h00007F00, 32'h00000100, 4'h2, 1, 1, 16'hFF81, 9);
        add(0, 4'h0, 0, 0, 4'h0, 1, 1, 16'h0000, 10);
        add(0, 4'h0, 0, 0, 4'h0, 1, 1, 16'h007F, 11);
        add(0, 4'h0, 0, 0, 4'h0, 0, 0, 16'h0000, 12);
        add(0, 4'h3, 32'h04030201, 32'hFDFDFDFD, 4'h1, 0, 0, 16'h0000, 12);
        add(0, 4'hA, 32'h04030201, 32'hFDFDFDFD, 4'h2, 0, 0, 16'h0000, 12);
        add(0, 4'h0, 0, 0, 4'h0, 1, 0, 16'hFFFD, 12);
        add(0, 4'h0, 0, 0, 4'h0, 1, 1, 16'hFFFA, 13);
        add(0, 4'h0, 0, 0, 4'h0, 0, 0, 16'h0000, 14);
        add(0, 4'h0, 0, 0, 4'h0, 0, 0, 16'h0000, 14);

        repeat (2) @(negedge clk);
        req_valid = 4'hF;
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_op_cnt", op_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_z", rsp_z, 0);
        chk("rst_rsp_id", rsp_id, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("release_ready", req_ready, 4'h1);
        @(negedge clk);
        rst = 1'b1; req_valid = '0;
        @(negedge clk);

        foreach (tv[i]) begin
            @(negedge clk);
            rst = tv[i].r; req_valid = tv[i].v; req_a = tv[i].a; req_b = tv[i].b;
            #1;
            chk($sformatf("tbl%0d_ready", i), req_ready, tv[i].rdy);
            s_rv.push_back(rsp_valid); s_id.push_back(rsp_id); s_z.push_back(rsp_z); s_cnt.push_back(op_cnt);
        end
        for (int i = 0; i + LAT - 2 < tv.size(); i++) begin
            int j;
            j = i + LAT - 2;
            chk($sformatf("tbl%0d_rsp_valid", i), s_rv[j], tv[i].rv);
            if (tv[i].rv) begin
                chk($sformatf("tbl%0d_rsp_id", i), s_id[j], tv[i].id);
                chk($sformatf("tbl%0d_rsp_z", i), s_z[j], tv[i].z);
            end
            if (tv[i].cnt >= 0) chk($sformatf("tbl%0d_op_cnt", i), s_cnt[j], tv[i].cnt);
        end

        cyc = 0;
        step(1'b1, '0, '0, '0, w);
        step(1'b1, '0, '0, '0, w);
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i] = 1'b1;
                    pa[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'h80 : 8'($urandom);
                    pb[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'h7F : 8'($urandom);
                end
            step(1'b0, pend, pa, pb, w);
            if (w >= 0) pend[w] = 1'b0;
        end

        // Reset one cycle after a transfer: the operation must vanish without a response.
        step(1'b1, '0, '0, '0, w);
        step(1'b0, 4'h1, 32'h00000007, 32'h00000009, w);
        step(1'b1, '0, '0, '0, w);
        step(1'b1, '0, '0, '0, w);
        for (int c = 0; c < 5; c++) step(1'b0, '0, '0, '0, w);

        step(1'b1, '0, '0, '0, w);
        step(1'b0, '0, '0, '0, w);
        req_a = 32'h00000003; req_b = 32'h00000005;
        for (int c = 0; c < 65535; c++) begin
            @(negedge clk);
            req_valid = 4'h1;
        end
        @(negedge clk);
        req_valid = '0;
        repeat (LAT + 1) @(negedge clk);
        #1;
        chk("cnt_ffff", op_cnt, 16'hFFFF);
        req_valid = 4'h1;
        #1;
        chk("wrap_ready", req_ready, 4'h1);
        lat = -1;
        for (int t = 1; t <= 8; t++) begin
            @(negedge clk);
            req_valid = '0;
            #1;
            if (rsp_valid && lat < 0) begin
                lat = t;
                chk("wrap_rsp_z", rsp_z, 16'h000F);
                chk("wrap_pre_cnt", op_cnt, 16'hFFFF);
            end
        end
        chk("wrap_latency", lat, LAT);
        chk("cnt_wrap", op_cnt, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
